// File: rtl/booth_issue_ctrl_if.sv
// Handshake and multiplier-side signals of the Booth issue/collect stage.
// The slave modport is the controller's view; master is the surrounding environment.
interface booth_issue_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic [15:0] in_y;
  logic        mul_start;
  logic [15:0] mul_x;
  logic [15:0] mul_y;
  logic        mul_busy;
  logic [31:0] mul_z;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_z;
  logic        out_err;

  modport slave (
    input  in_valid, in_x, in_y, mul_busy, mul_z, out_ready,
    output in_ready, mul_start, mul_x, mul_y, out_valid, out_z, out_err
  );

  modport master (
    output in_valid, in_x, in_y, mul_busy, mul_z, out_ready,
    input  in_ready, mul_start, mul_x, mul_y, out_valid, out_z, out_err
  );
endinterface

// File: rtl/booth_issue_ctrl.sv
// Issue/collect controller for the 16x16 signed Booth multiplier: operand FIFO,
// single-flight launch FSM, product capture and a watchdog for a hung multiplier.
module booth_issue_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  booth_issue_ctrl_if.slave       bus,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, LAUNCH, ARM, RUN, OUT} state_t;

  state_t        state, state_nxt;
  logic [15:0]   x_mem [DEPTH];
  logic [15:0]   y_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [WW-1:0] wdog;
  logic [15:0]   mul_x_q, mul_y_q;
  logic [31:0]   out_z_q;
  logic          out_err_q;
  logic          full, empty, push, pop, capture, timeout, wdog_expired;

  assign full         = (count == (AW+1)'(DEPTH));
  assign empty        = (count == '0);
  assign push         = bus.in_valid && !full;
  assign wdog_expired = (wdog == WW'(TIMEOUT - 1));

  assign bus.in_ready  = !full;
  assign bus.mul_start = (state == LAUNCH);
  assign bus.mul_x     = mul_x_q;
  assign bus.mul_y     = mul_y_q;
  assign bus.out_valid = (state == OUT);
  assign bus.out_z     = out_z_q;
  assign bus.out_err   = out_err_q;
  assign fifo_count    = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Busy is only looked at from ARM onward, since the multiplier raises it one edge after start.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: state_nxt = ARM;
      ARM: begin
        if (wdog_expired) begin
          timeout   = 1'b1;
          state_nxt = OUT;
        end else if (bus.mul_busy) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!bus.mul_busy) begin
          capture   = 1'b1;
          state_nxt = OUT;
        end else if (wdog_expired) begin
          timeout   = 1'b1;
          state_nxt = OUT;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      x_mem[wr_ptr] <= bus.in_x;
      y_mem[wr_ptr] <= bus.in_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Operands stay on mul_x/mul_y until the next pop; the product is captured as-is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_x_q   <= '0;
      mul_y_q   <= '0;
      out_z_q   <= '0;
      out_err_q <= 1'b0;
      wdog      <= '0;
    end else begin
      if (pop) begin
        mul_x_q <= x_mem[rd_ptr];
        mul_y_q <= y_mem[rd_ptr];
      end
      if (state == LAUNCH) begin
        wdog <= '0;
      end else if (state == ARM || state == RUN) begin
        wdog <= wdog + 1'b1;
      end
      if (capture) begin
        out_z_q   <= bus.mul_z;
        out_err_q <= 1'b0;
      end else if (timeout) begin
        out_z_q   <= '0;
        out_err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_booth_issue_ctrl.sv
// Scoreboard bench for booth_issue_ctrl with a behavioural Booth multiplier that
// can be forced to a stuck-low or stuck-high busy to exercise the watchdog.
module tb_booth_issue_ctrl;

  localparam int DEPTH      = 4;
  localparam int TIMEOUT    = 64;
  localparam int MUL_CYCLES = 18;

  typedef struct packed {
    logic [31:0] z;
    logic        err;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [$clog2(DEPTH):0] fifo_count;

  booth_issue_ctrl_if bus ();

  booth_issue_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   start_count = 0;
  int   mul_mode = 0;

  // Multiplier model: busy rises one edge after start, product appears as busy falls.
  logic               model_busy;
  int                 model_cnt;
  logic signed [31:0] model_prod;
  logic [31:0]        model_z;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_busy <= 1'b0;
      model_cnt  <= 0;
      model_prod <= '0;
      model_z    <= '0;
    end else if (model_busy) begin
      if (model_cnt <= 1) begin
        model_busy <= 1'b0;
        model_z    <= model_prod;
      end else begin
        model_cnt <= model_cnt - 1;
      end
    end else if (bus.mul_start) begin
      model_busy <= 1'b1;
      model_cnt  <= MUL_CYCLES;
      model_prod <= $signed(bus.mul_x) * $signed(bus.mul_y);
    end
  end

  assign bus.mul_busy = (mul_mode == 1) ? 1'b0 : (mul_mode == 2) ? 1'b1 : model_busy;
  assign bus.mul_z    = model_z;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic report_timeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: wait bound expired", name);
  endtask

  // Monitor: counts start pulses and scores every accepted result against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.mul_start) begin
        start_count++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_result: got z=0x%08h err=%0b, expected none", bus.out_z, bus.out_err);
        end else begin
          e = exp_q.pop_front();
          check_output("result_z", bus.out_z, e.z);
          check_output("result_err", 32'(bus.out_err), 32'(e.err));
        end
      end
    end
  end

  task automatic apply_stimulus(input logic [15:0] x, input logic [15:0] y,
                                input logic [31:0] z, input logic err);
    bit accepted = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    bus.in_y     = y;
    for (int i = 0; i < 400 && !accepted; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        accepted = 1'b1;
        exp_q.push_back('{z: z, err: err});
      end
    end
    if (!accepted) begin
      bus.in_valid = 1'b0;
      report_timeout("push_accept");
    end
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    bit done = 1'b0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        done = 1'b1;
      end
    end
    if (!done) begin
      report_timeout(name);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid(input string name, input int max_cycles, output int cycles);
    bit seen = 1'b0;
    cycles = 0;
    for (int i = 1; i <= max_cycles && !seen; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        seen   = 1'b1;
        cycles = i;
      end
    end
    if (!seen) begin
      report_timeout(name);
    end
  endtask

  task automatic wait_start(input string name, input int max_cycles);
    bit seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(posedge clk);
      #1;
      if (bus.mul_start) begin
        seen = 1'b1;
      end
    end
    if (!seen) begin
      report_timeout(name);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int cyc;

    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check_output("reset_fifo_count", 32'(fifo_count), 32'd0);
    check_output("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("reset_mul_start", 32'(bus.mul_start), 32'd0);
    check_output("reset_out_z", bus.out_z, 32'd0);
    check_output("reset_out_err", 32'(bus.out_err), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] basic multiply");
    bus.out_ready = 1'b1;
    start_count   = 0;
    apply_stimulus(16'h0003, 16'h0005, 32'h0000_000F, 1'b0);
    bus.in_valid = 1'b0;
    wait_out_valid("basic_out_valid", 40, cyc);
    check_output("basic_latency_window", 32'(cyc >= 20 && cyc <= 22), 32'd1);
    wait_drain("basic_drain", 40);
    check_output("basic_start_count", 32'(start_count), 32'd1);

    $display("[TB] signed operands");
    start_count = 0;
    apply_stimulus(16'hFFFE, 16'h0007, 32'hFFFF_FFF2, 1'b0);
    apply_stimulus(16'h8000, 16'h8000, 32'h4000_0000, 1'b0);
    apply_stimulus(16'h7FFF, 16'hFFFF, 32'hFFFF_8001, 1'b0);
    bus.in_valid = 1'b0;
    wait_drain("signed_drain", 200);
    check_output("signed_start_count", 32'(start_count), 32'd3);

    $display("[TB] backpressure");
    bus.out_ready = 1'b0;
    start_count   = 0;
    apply_stimulus(16'd1, 16'd2, 32'd2, 1'b0);
    apply_stimulus(16'd2, 16'd3, 32'd6, 1'b0);
    apply_stimulus(16'd3, 16'd4, 32'd12, 1'b0);
    apply_stimulus(16'hFFFF, 16'd5, 32'hFFFF_FFFB, 1'b0);
    apply_stimulus(16'd4, 16'hFFFC, 32'hFFFF_FFF0, 1'b0);
    bus.in_valid = 1'b0;
    check_output("bp_fifo_full_count", 32'(fifo_count), 32'(DEPTH));
    check_output("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    wait_out_valid("bp_first_result", 40, cyc);
    repeat (6) @(posedge clk);
    #1;
    check_output("bp_hold_out_valid", 32'(bus.out_valid), 32'd1);
    check_output("bp_hold_out_z", bus.out_z, 32'd2);
    check_output("bp_hold_fifo_count", 32'(fifo_count), 32'(DEPTH));
    bus.out_ready = 1'b1;
    apply_stimulus(16'd100, 16'd100, 32'h0000_2710, 1'b0);
    bus.in_valid = 1'b0;
    wait_drain("bp_drain", 600);
    check_output("bp_start_count", 32'(start_count), 32'd6);

    $display("[TB] simultaneous push and pop");
    bus.out_ready = 1'b0;
    apply_stimulus(16'd5, 16'd6, 32'h0000_001E, 1'b0);
    apply_stimulus(16'd7, 16'd8, 32'h0000_0038, 1'b0);
    apply_stimulus(16'd9, 16'd10, 32'h0000_005A, 1'b0);
    apply_stimulus(16'd11, 16'd12, 32'h0000_0084, 1'b0);
    bus.in_valid = 1'b0;
    wait_out_valid("pp_first_result", 40, cyc);
    check_output("pp_count_before", 32'(fifo_count), 32'(DEPTH - 1));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_output("pp_idle_out_valid", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_x     = 16'd13;
    bus.in_y     = 16'd14;
    @(posedge clk);
    #1;
    exp_q.push_back('{z: 32'h0000_00B6, err: 1'b0});
    bus.in_valid = 1'b0;
    check_output("pp_count_after", 32'(fifo_count), 32'(DEPTH - 1));
    check_output("pp_launch_start", 32'(bus.mul_start), 32'd1);
    wait_drain("pp_drain", 400);

    $display("[TB] watchdog, busy stuck low");
    mul_mode = 1;
    apply_stimulus(16'd1, 16'd1, 32'd0, 1'b1);
    bus.in_valid = 1'b0;
    wait_start("wd0_start", 10);
    wait_out_valid("wd0_out_valid", TIMEOUT + 10, cyc);
    check_output("wd0_latency_window", 32'(cyc >= TIMEOUT - 1 && cyc <= TIMEOUT + 2), 32'd1);
    wait_drain("wd0_drain", 20);

    $display("[TB] watchdog, busy stuck high");
    mul_mode = 2;
    apply_stimulus(16'd1, 16'd1, 32'd0, 1'b1);
    bus.in_valid = 1'b0;
    wait_start("wd1_start", 10);
    wait_out_valid("wd1_out_valid", TIMEOUT + 10, cyc);
    check_output("wd1_latency_window", 32'(cyc >= TIMEOUT - 1 && cyc <= TIMEOUT + 2), 32'd1);
    wait_drain("wd1_drain", 20);
    mul_mode = 0;
    repeat (25) @(posedge clk);
    #1;

    $display("[TB] reset mid-operation");
    apply_stimulus(16'd2, 16'd2, 32'd4, 1'b0);
    apply_stimulus(16'd3, 16'd3, 32'd9, 1'b0);
    apply_stimulus(16'd4, 16'd4, 32'd16, 1'b0);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20 && !bus.mul_busy; i++) begin
      @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_busy_before", 32'(bus.mul_busy), 32'd1);
    check_output("rst_count_before", 32'(fifo_count), 32'd2);
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check_output("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_output("rst_fifo_count", 32'(fifo_count), 32'd0);
    check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("rst_mul_start", 32'(bus.mul_start), 32'd0);
    check_output("rst_mul_x", 32'(bus.mul_x), 32'd0);
    check_output("rst_mul_y", 32'(bus.mul_y), 32'd0);
    check_output("rst_out_z", bus.out_z, 32'd0);
    check_output("rst_out_err", 32'(bus.out_err), 32'd0);
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    start_count = 0;
    repeat (40) @(posedge clk);
    #1;
    check_output("rst_no_start_after", 32'(start_count), 32'd0);
    check_output("rst_no_result_after", 32'(bus.out_valid), 32'd0);
    apply_stimulus(16'hFFFD, 16'hFFFD, 32'd9, 1'b0);
    bus.in_valid = 1'b0;
    wait_drain("rst_recover_drain", 60);
    check_output("rst_recover_start_count", 32'(start_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
